// File: rtl/adc_rx_pkg.sv
// Shared types and elaboration helpers for the multi-channel serial ADC receiver.
package adc_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      QUIET = 2'd2
   } rx_state_t;

   // Width of the shared frame/quiet counter: enough to hold max(frame_len, quiet_cyc)-1.
   function automatic int cnt_width(input int frame_len, input int quiet_cyc);
      int m;
      m = (frame_len > quiet_cyc) ? frame_len : quiet_cyc;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   // Legal parameter combinations for adc_serial_rx_mc.
   function automatic bit params_ok(input int data_w, input int frame_len,
                                    input int n_ch, input int quiet_cyc);
      return (data_w >= 1) && (data_w <= frame_len) && (frame_len >= 2) &&
             (n_ch >= 1) && (quiet_cyc >= 1);
   endfunction

endpackage

// File: rtl/adc_shift_lane.sv
// One serial data lane: captures sdata on the falling edge of sclk while enabled.
module adc_shift_lane #(
   parameter int FRAME_LEN = 16
) (
   input  logic                 sclk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sdata,
   output logic [FRAME_LEN-1:0] q
);

   // MSB-first shift; never cleared between frames since each frame overwrites all bits.
   always_ff @(negedge sclk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= {q[FRAME_LEN-2:0], sdata};
   end

endmodule

// File: rtl/adc_serial_rx_mc.sv
// Multi-channel serial SAR ADC receiver running on the ADC serial clock.
//
// state | meaning
// IDLE  | cs_n high, waiting for start or cont_mode
// CONV  | cs_n low, lanes shifting, counter 0..FRAME_LEN-1
// QUIET | cs_n high, counter 0..QUIET_CYC-1, then CONV (cont_mode) or IDLE
module adc_serial_rx_mc
   import adc_rx_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int FRAME_LEN = 16,
   parameter int N_CH      = 2,
   parameter int QUIET_CYC = 2
) (
   input  logic                     sclk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          sdata,
   input  logic                     start,
   input  logic                     cont_mode,
   input  logic                     ready,
   input  logic                     clr_ovr,
   output logic                     cs_n,
   output logic                     busy,
   output logic                     valid,
   output logic [N_CH*DATA_W-1:0]   dout,
   output logic                     overrun
);

   localparam int CNT_W = cnt_width(FRAME_LEN, QUIET_CYC);
   localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);

   if (!params_ok(DATA_W, FRAME_LEN, N_CH, QUIET_CYC)) begin : g_bad_params
      $error("adc_serial_rx_mc: illegal parameter combination");
   end

   rx_state_t             state;
   rx_state_t             next_state;
   logic [CNT_W-1:0]      cnt;
   logic                  cnt_clr;
   logic                  load;
   logic                  lane_en;
   logic [FRAME_LEN-1:0]  lane_q [N_CH];
   logic [N_CH*DATA_W-1:0] lane_word;

   // State register.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; start only matters in IDLE, cont_mode in IDLE and at end of QUIET.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start || cont_mode) next_state = CONV;
         CONV:    if (cnt == CONV_LAST)   next_state = QUIET;
         QUIET:   if (cnt == QUIET_LAST)  next_state = cont_mode ? CONV : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: busy, frame-end load strobe and counter clear.
   always_comb begin
      busy    = (state != IDLE);
      load    = (state == CONV) && (cnt == CONV_LAST);
      cnt_clr = (state == IDLE) || (next_state != state);
   end

   // Shared phase counter, restarted on every state change.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (cnt_clr)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   // Chip select registered from the next state so it is glitch-free and aligned with CONV.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst)
         cs_n <= 1'b1;
      else
         cs_n <= (next_state != CONV);
   end

   assign lane_en = ~cs_n;

   for (genvar g = 0; g < N_CH; g++) begin : g_lane
      adc_shift_lane #(
         .FRAME_LEN (FRAME_LEN)
      ) u_lane (
         .sclk  (sclk),
         .rst   (rst),
         .en    (lane_en),
         .sdata (sdata[g]),
         .q     (lane_q[g])
      );
      // Keep only the trailing DATA_W bits; leading bits of the frame are discarded.
      assign lane_word[g*DATA_W +: DATA_W] = lane_q[g][DATA_W-1:0];
   end

   // Output register and valid handshake; a load always wins over consumption.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= lane_word;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

   // Sticky overrun: an unconsumed word overwritten by a load; set beats clear.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst)
         overrun <= 1'b0;
      else if (load && valid && !ready)
         overrun <= 1'b1;
      else if (clr_ovr)
         overrun <= 1'b0;
   end

endmodule

// File: tb/tb_adc_serial_rx_mc.sv
// Directed bench for adc_serial_rx_mc with a simple ADC lane model.
module tb_adc_serial_rx_mc;

   logic        sclk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sdata = '0;
   logic        start = 1'b0;
   logic        cont_mode = 1'b0;
   logic        ready = 1'b0;
   logic        clr_ovr = 1'b0;
   logic        cs_n;
   logic        busy;
   logic        valid;
   logic [23:0] dout;
   logic        overrun;

   logic [15:0] w0 = '0;
   logic [15:0] w1 = '0;
   int          bidx = 0;

   int n_chk = 0;
   int n_pass = 0;

   adc_serial_rx_mc #(
      .DATA_W    (12),
      .FRAME_LEN (16),
      .N_CH      (2),
      .QUIET_CYC (2)
   ) dut (
      .sclk      (sclk),
      .rst       (rst),
      .sdata     (sdata),
      .start     (start),
      .cont_mode (cont_mode),
      .ready     (ready),
      .clr_ovr   (clr_ovr),
      .cs_n      (cs_n),
      .busy      (busy),
      .valid     (valid),
      .dout      (dout),
      .overrun   (overrun)
   );

   always #5 sclk = ~sclk;

   // ADC model: presents the next MSB-first bit shortly after each rising edge while selected.
   always @(posedge sclk) begin
      #1;
      if (cs_n === 1'b1) begin
         bidx = 0;
      end else if (bidx < 16) begin
         sdata = {w1[15-bidx], w0[15-bidx]};
         bidx  = bidx + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < bound) begin
         @(negedge sclk);
         n++;
      end
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   // Leaves the caller at the first negedge after the accepting edge E.
   task automatic start_frame(input logic [15:0] a, input logic [15:0] b);
      w0 = a;
      w1 = b;
      start = 1'b1;
      @(negedge sclk);
      start = 1'b0;
   endtask

   task automatic single(input logic [15:0] a, input logic [15:0] b);
      start_frame(a, b);
      wait_idle(40);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      int vcnt;
      int bcnt;
      int fall2;
      int starts;
      int idles;
      int n;
      logic prev;

      repeat (3) @(negedge sclk);
      check("rst_cs_n",    32'(cs_n),    32'd1);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_valid",   32'(valid),   32'd0);
      check("rst_dout",    32'(dout),    32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      @(negedge sclk);

      // Single shot.
      start_frame(16'h0ABC, 16'h0123);
      check("ss_cs_low",  32'(cs_n), 32'd0);
      check("ss_busy",    32'(busy), 32'd1);
      lows = 0;
      while (cs_n === 1'b0 && lows < 40) begin
         lows++;
         @(negedge sclk);
      end
      check("ss_cs_low_periods", 32'(lows), 32'd16);
      check("ss_valid",   32'(valid),   32'd1);
      check("ss_dout",    32'(dout),    32'h123ABC);
      check("ss_overrun", 32'(overrun), 32'd0);
      bcnt = 0;
      while (busy === 1'b1 && bcnt < 40) begin
         bcnt++;
         @(negedge sclk);
      end
      check("ss_busy_tail", 32'(bcnt), 32'd2);
      ready = 1'b1;
      @(negedge sclk);
      check("ss_consumed", 32'(valid), 32'd0);

      // Continuous mode, ready held high.
      w0 = 16'h0555;
      w1 = 16'h0AAA;
      cont_mode = 1'b1;
      @(negedge sclk);
      lows = 0;
      vcnt = 0;
      fall2 = -1;
      prev = cs_n;
      for (int i = 0; i < 54; i++) begin
         if (cs_n === 1'b0) lows++;
         if (valid === 1'b1) vcnt++;
         if (i > 0 && prev === 1'b1 && cs_n === 1'b0 && fall2 < 0) fall2 = i;
         prev = cs_n;
         @(negedge sclk);
      end
      check("cm_low_total", 32'(lows),    32'd48);
      check("cm_loads",     32'(vcnt),    32'd3);
      check("cm_period",    32'(fall2),   32'd18);
      check("cm_overrun",   32'(overrun), 32'd0);
      check("cm_dout",      32'(dout),    32'hAAA555);
      repeat (4) @(negedge sclk);
      cont_mode = 1'b0;
      n = 0;
      vcnt = 0;
      while (busy !== 1'b0 && n < 60) begin
         @(negedge sclk);
         n++;
         if (valid === 1'b1) vcnt++;
      end
      check("cm_drop_idle",  32'(busy), 32'd0);
      check("cm_drop_loads", 32'(vcnt), 32'd1);
      repeat (3) @(negedge sclk);
      check("cm_stays_idle", 32'(cs_n), 32'd1);
      ready = 1'b0;

      // Consumer stall across two frames.
      single(16'h0123, 16'h0456);
      check("st1_valid",   32'(valid),   32'd1);
      check("st1_dout",    32'(dout),    32'h456123);
      check("st1_overrun", 32'(overrun), 32'd0);
      single(16'h0FFF, 16'h0000);
      check("st2_dout",    32'(dout),    32'h000FFF);
      check("st2_overrun", 32'(overrun), 32'd1);
      check("st2_valid",   32'(valid),   32'd1);
      clr_ovr = 1'b1;
      @(negedge sclk);
      clr_ovr = 1'b0;
      check("clr_ovr", 32'(overrun), 32'd0);

      // clr_ovr held across a stalled load: set must win.
      clr_ovr = 1'b1;
      start_frame(16'h0F0F, 16'h00F0);
      repeat (16) @(negedge sclk);
      clr_ovr = 1'b0;
      check("ovr_set_wins", 32'(overrun), 32'd1);
      check("ovr_dout",     32'(dout),    32'h0F0F0F);
      @(negedge sclk);
      check("ovr_sticky",   32'(overrun), 32'd1);
      wait_idle(10);
      clr_ovr = 1'b1;
      @(negedge sclk);
      clr_ovr = 1'b0;

      // Load and ready on the same edge.
      start_frame(16'h0321, 16'h0654);
      repeat (15) @(negedge sclk);
      check("lr_pre_valid", 32'(valid), 32'd1);
      ready = 1'b1;
      @(negedge sclk);
      ready = 1'b0;
      check("lr_valid",   32'(valid),   32'd1);
      check("lr_dout",    32'(dout),    32'h654321);
      check("lr_overrun", 32'(overrun), 32'd0);
      wait_idle(10);
      check("lr_valid_hold", 32'(valid), 32'd1);

      // Reset in the middle of a frame.
      start_frame(16'h0FFF, 16'h0FFF);
      repeat (7) @(negedge sclk);
      rst = 1'b1;
      #1;
      check("mr_cs_n",  32'(cs_n),  32'd1);
      check("mr_valid", 32'(valid), 32'd0);
      check("mr_dout",  32'(dout),  32'd0);
      check("mr_busy",  32'(busy),  32'd0);
      @(negedge sclk);
      rst = 1'b0;
      @(negedge sclk);
      single(16'h0ABC, 16'h0123);
      check("mr_after_valid", 32'(valid), 32'd1);
      check("mr_after_dout",  32'(dout),  32'h123ABC);

      // start held high with cont_mode low: one frame per IDLE entry.
      ready = 1'b1;
      @(negedge sclk);
      ready = 1'b0;
      w0 = 16'h0ABC;
      w1 = 16'h0123;
      start = 1'b1;
      @(negedge sclk);
      starts = 0;
      idles = 0;
      fall2 = -1;
      prev = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (prev === 1'b1 && cs_n === 1'b0) begin
            starts++;
            if (starts == 2) fall2 = i;
         end
         if (busy === 1'b0) idles++;
         prev = cs_n;
         @(negedge sclk);
      end
      start = 1'b0;
      check("sh_frames",   32'(starts), 32'd3);
      check("sh_restart",  32'(fall2),  32'd19);
      check("sh_idle_cyc", 32'(idles),  32'd2);
      wait_idle(60);
      check("sh_dout", 32'(dout), 32'h123ABC);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
